// File: rtl/sine_wave_player_pkg.sv
// Shared constants for the sine ROM, its player and the surrounding top level,
// plus the player's control-state encoding.
package sine_wave_player_pkg;

    localparam int unsigned TABLE_LEN   = 632;
    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned DATA_W      = 13;
    localparam int unsigned ROM_LATENCY = 1;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sine_wave_player_sync_fifo.sv
// Parameterised show-ahead synchronous FIFO with occupancy count; a simultaneous
// write and pop are both honoured, even when full. Head reads as zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_wr,
    input  logic [WIDTH-1:0]           iv_wr_data,
    input  logic                       i_rd,
    output logic [WIDTH-1:0]           ov_rd_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] ov_count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_rd    = i_rd && (count_q != '0);
        // When full, a write is legal only because the head slot is being popped.
        do_wr    = i_wr && ((count_q != CW'(DEPTH)) || do_rd);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = iv_wr_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_rd) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_empty    = (count_q == '0);
    assign ov_count   = count_q;
    assign ov_rd_data = o_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sine_wave_player.sv
// Phase-stepping sine ROM reader: issues addresses modulo TABLE_LEN under FIFO
// credit, absorbs ROM latency and streams samples out on valid/ready.
module sine_wave_player #(
    parameter int unsigned TABLE_LEN   = sine_wave_player_pkg::TABLE_LEN,
    parameter int unsigned ADDR_W      = sine_wave_player_pkg::ADDR_W,
    parameter int unsigned DATA_W      = sine_wave_player_pkg::DATA_W,
    parameter int unsigned ROM_LATENCY = sine_wave_player_pkg::ROM_LATENCY,
    parameter int unsigned FIFO_DEPTH  = sine_wave_player_pkg::FIFO_DEPTH,
    parameter int unsigned CNT_W       = sine_wave_player_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] iv_step,
    output logic [ADDR_W-1:0] ov_rom_addr,
    input  logic [DATA_W-1:0] iv_rom_data,
    output logic [DATA_W-1:0] ov_sample,
    output logic              o_sample_valid,
    input  logic              i_sample_ready,
    output logic              o_busy,
    output logic              o_period_done,
    output logic [CNT_W-1:0]  ov_period_cnt
);
    import sine_wave_player_pkg::*;

    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IFW = $clog2(ROM_LATENCY + 1);
    localparam int unsigned OCW = FCW + IFW + 1;
    localparam logic [ADDR_W:0] TLEN = (ADDR_W + 1)'(TABLE_LEN);

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W-1:0]    step_q, step_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 period_done_q, period_done_d;
    logic                 busy_q, busy_d;
    logic [ROM_LATENCY-1:0] vld_q, vld_d;

    logic [ADDR_W-1:0]    step_sat, addr_next;
    logic [ADDR_W:0]      sum;
    logic [IFW-1:0]       inflight;
    logic [FCW-1:0]       fifo_count;
    logic                 fifo_empty, wrap, issue, pop;

    always_comb begin
        step_sat  = ({1'b0, iv_step} >= TLEN) ? ADDR_W'(TABLE_LEN - 1) : iv_step;
        sum       = {1'b0, addr_q} + {1'b0, step_q};
        wrap      = (sum >= TLEN);
        addr_next = wrap ? ADDR_W'(sum - TLEN) : sum[ADDR_W-1:0];

        // Credit: reads in flight plus buffered samples may never exceed the FIFO.
        inflight  = IFW'($countones(vld_q));
        issue     = (state_q == ST_RUN) &&
                    ((OCW'(inflight) + OCW'(fifo_count)) < OCW'(FIFO_DEPTH));
        vld_d     = ROM_LATENCY'({vld_q, issue});

        state_d       = state_q;
        addr_d        = addr_q;
        step_d        = step_q;
        cnt_d         = cnt_q;
        period_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (i_start && !i_stop) begin
                    state_d = ST_RUN;
                    step_d  = step_sat;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = addr_next;
                    if (wrap) begin
                        period_done_d = 1'b1;
                        cnt_d         = cnt_q + 1'b1;
                        step_d        = step_sat;
                    end
                end
                if (i_stop) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((vld_q == '0) && fifo_empty) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            step_q        <= '0;
            cnt_q         <= '0;
            period_done_q <= 1'b0;
            busy_q        <= 1'b0;
            vld_q         <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            step_q        <= step_d;
            cnt_q         <= cnt_d;
            period_done_q <= period_done_d;
            busy_q        <= busy_d;
            vld_q         <= vld_d;
        end
    end

    assign pop = o_sample_valid && i_sample_ready;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr       (vld_q[ROM_LATENCY-1]),
        .iv_wr_data (iv_rom_data),
        .i_rd       (pop),
        .ov_rd_data (ov_sample),
        .o_empty    (fifo_empty),
        .ov_count   (fifo_count)
    );

    assign o_sample_valid = !fifo_empty;
    assign ov_rom_addr    = addr_q;
    assign o_busy         = busy_q;
    assign o_period_done  = period_done_q;
    assign ov_period_cnt  = cnt_q;

endmodule

// File: tb/tb_sine_wave_player.sv
// Directed bench for sine_wave_player: ROM model returns data = address one
// cycle later; expected samples come from a modulo-632 phase model.
module tb_sine_wave_player;
    import sine_wave_player_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_start, i_stop, i_sample_ready;
    logic [ADDR_W-1:0] iv_step;
    logic [ADDR_W-1:0] ov_rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] ov_sample;
    logic              o_sample_valid, o_busy, o_period_done;
    logic [CNT_W-1:0]  ov_period_cnt;

    int vectors    = 0;
    int miscompares = 0;
    int exp_s      = 0;
    int cur_step   = 0;
    int pd_count   = 0;

    sine_wave_player #(
        .TABLE_LEN   (632),
        .ADDR_W      (10),
        .DATA_W      (13),
        .ROM_LATENCY (1),
        .FIFO_DEPTH  (4),
        .CNT_W       (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_start        (i_start),
        .i_stop         (i_stop),
        .iv_step        (iv_step),
        .ov_rom_addr    (ov_rom_addr),
        .iv_rom_data    (rom_data),
        .ov_sample      (ov_sample),
        .o_sample_valid (o_sample_valid),
        .i_sample_ready (i_sample_ready),
        .o_busy         (o_busy),
        .o_period_done  (o_period_done),
        .ov_period_cnt  (ov_period_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= {{(DATA_W-ADDR_W){1'b0}}, ov_rom_addr};

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int s);
        return (s >= 632) ? 631 : s;
    endfunction

    task automatic advance();
        exp_s += cur_step;
        if (exp_s >= 632) begin
            exp_s -= 632;
            cur_step = sat(int'(iv_step));
        end
    endtask

    // Pulses start with the given step and checks the two latency cycles before first valid.
    task automatic start_run(input int step, input string tag);
        @(negedge clk);
        iv_step  = ADDR_W'(step);
        i_start  = 1'b1;
        exp_s    = 0;
        cur_step = sat(step);
        pd_count = 0;
        @(negedge clk);
        i_start = 1'b0;
        check({tag, "_busy"},  o_busy, 1);
        check({tag, "_addr0"}, ov_rom_addr, 0);
        check({tag, "_cnt0"},  ov_period_cnt, 0);
        check({tag, "_v1"},    o_sample_valid, 0);
        @(negedge clk);
        check({tag, "_v2"},    o_sample_valid, 0);
    endtask

    task automatic accept_n(input int n, input string tag, input int wrap_addr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_valid"}, o_sample_valid, 1);
            check({tag, "_sample"}, ov_sample, exp_s);
            if (o_period_done) begin
                pd_count++;
                if (wrap_addr >= 0) check({tag, "_wrapaddr"}, ov_rom_addr, wrap_addr);
            end
            advance();
        end
    endtask

    task automatic drain(input string tag);
        int  last;
        int  last_issued;
        bit  done;
        done = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, o_sample_valid, 1);
        check({tag, "_sample"}, ov_sample, exp_s);
        last = exp_s;
        advance();
        last_issued = int'(ov_rom_addr);
        i_stop = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            i_stop = 1'b0;
            if (!o_busy) done = 1'b1;
            else if (o_sample_valid) begin
                check({tag, "_dsample"}, ov_sample, exp_s);
                last = exp_s;
                advance();
            end
        end
        check({tag, "_idle"},  o_busy, 0);
        check({tag, "_last"},  last, last_issued);
        check({tag, "_addr"},  ov_rom_addr, 0);
        check({tag, "_empty"}, o_sample_valid, 0);
    endtask

    initial begin
        int stall_addr;
        reset = 1'b1; i_start = 1'b0; i_stop = 1'b0;
        i_sample_ready = 1'b1; iv_step = '0;
        repeat (2) @(negedge clk);
        check("rst_addr",  ov_rom_addr, 0);
        check("rst_valid", o_sample_valid, 0);
        check("rst_sample", ov_sample, 0);
        check("rst_busy",  o_busy, 0);
        check("rst_pd",    o_period_done, 0);
        check("rst_cnt",   ov_period_cnt, 0);
        reset = 1'b0;

        // Step 1: full period plus two, one sample per cycle, one wrap at address 0
        start_run(1, "s1");
        accept_n(634, "s1", 0);
        check("s1_pdcount", pd_count, 1);
        check("s1_cnt", ov_period_cnt, 1);
        @(negedge clk);
        check("stop_sample", ov_sample, 2);
        check("stop_addr", ov_rom_addr, 4);
        i_stop = 1'b1;
        advance();
        @(negedge clk);
        i_stop = 1'b0;
        check("stop_s3", ov_sample, 3);
        @(negedge clk);
        check("stop_s4", ov_sample, 4);
        check("stop_busy_a", o_busy, 1);
        @(negedge clk);
        check("stop_valid", o_sample_valid, 0);
        check("stop_busy_b", o_busy, 1);
        @(negedge clk);
        check("stop_busy_c", o_busy, 0);
        check("stop_addr0", ov_rom_addr, 0);
        check("stop_valid2", o_sample_valid, 0);

        // Step 5: wrap pulse coincides with issuing address 3
        start_run(5, "s5");
        accept_n(129, "s5", 3);
        check("s5_pdcount", pd_count, 1);
        check("s5_cnt", ov_period_cnt, 1);

        // Backpressure: FIFO fills, address stalls, head sample held
        @(negedge clk);
        i_sample_ready = 1'b0;
        stall_addr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_valid", o_sample_valid, 1);
            check("stall_sample", ov_sample, exp_s);
            if (i == 10) stall_addr = int'(ov_rom_addr);
            if (i == 19) check("stall_addr", ov_rom_addr, stall_addr);
        end
        i_sample_ready = 1'b1;
        advance();
        accept_n(30, "resume", -1);
        drain("s5_drain");

        // Step change 1 -> 3 at sample 100 takes effect only after the wrap
        start_run(1, "chg");
        accept_n(101, "chg_a", 0);
        iv_step = 10'd3;
        accept_n(535, "chg_b", 0);
        check("chg_last", exp_s, 12);
        check("chg_pdcount", pd_count, 1);
        check("chg_cnt", ov_period_cnt, 1);

        // Reset mid-run with samples buffered
        @(negedge clk);
        i_sample_ready = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_valid", o_sample_valid, 0);
        check("mrst_busy",  o_busy, 0);
        check("mrst_cnt",   ov_period_cnt, 0);
        check("mrst_addr",  ov_rom_addr, 0);
        reset = 1'b0;
        i_sample_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_valid2", o_sample_valid, 0);

        // Start and stop together in IDLE: stays idle
        @(negedge clk);
        i_start = 1'b1; i_stop = 1'b1; iv_step = 10'd1;
        @(negedge clk);
        i_start = 1'b0; i_stop = 1'b0;
        check("ss_busy", o_busy, 0);
        @(negedge clk);
        check("ss_valid", o_sample_valid, 0);

        // Step 0: constant sample 0, no wraps
        start_run(0, "z");
        accept_n(10, "z", -1);
        check("z_pdcount", pd_count, 0);
        check("z_addr", ov_rom_addr, 0);
        drain("z_drain");

        // Step 1000 saturates to 631: 0, 631, 630, 629 with a wrap every issue after the first
        start_run(1000, "sat");
        accept_n(4, "sat", -1);
        check("sat_pdcount", pd_count, 4);
        check("sat_cnt", ov_period_cnt, 4);
        drain("sat_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
